imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//   Shares the single-port synchronous instruction/data RAM between two requesters: the fetch stage (read-only)
//   and the load/store unit (read/write). Grants at most one access per cycle; data port has priority,
//   with a starvation guard that forces a fetch grant. Returns read data one cycle after grant, tagged to the owner.
//   Sits between fetch / memory stages and the ram1port instance.
// PARAMETERS
//   AW          16  address width (word addressed)
//   DW          16  data width
//   STARVE_MAX  4   consecutive denied fetch cycles before fetch is forced to win (>=1)
// PORTS
//   clk        in   1   single clock; all state updates on posedge
//   rst        in   1   synchronous, active-high reset
//   f_req      in   1   fetch requests a read this cycle
//   f_addr     in   AW  fetch address (PC)
//   f_gnt      out  1   fetch access issued to RAM this cycle (comb.)
//   f_rvalid   out  1   f_rdata valid (read granted previous cycle)
//   f_rdata    out  DW  instruction word
//   d_req      in   1   data port requests access
//   d_we       in   1   1 = write, 0 = read (qualified by d_req)
//   d_addr     in   AW  data address
//   d_wdata    in   DW  write data
//   d_gnt      out  1   data access issued to RAM this cycle (comb.)
//   d_rvalid   out  1   d_rdata valid (data read granted previous cycle)
//   d_rdata    out  DW  load data
//   ram_addr   out  AW  to RAM address
//   ram_data   out  DW  to RAM write data
//   ram_wren   out  1   to RAM write enable
//   ram_q      in   DW  from RAM; valid the cycle after address is presented
// BEHAVIOUR
//   - Reset: f_rvalid=d_rvalid=0, starve_cnt=0; while rst=1, f_gnt=d_gnt=ram_wren=0.
//   - Grant (comb., same cycle): only d_req -> d_gnt; only f_req -> f_gnt; both -> d_gnt unless
//     starve_cnt==STARVE_MAX, then f_gnt. Never both grants high. Requester holds req/addr until granted.
//   - starve_cnt: +1 (saturating at STARVE_MAX) when f_req & ~f_gnt; cleared to 0 when f_gnt or ~f_req.
//   - RAM drive: d_gnt -> ram_addr=d_addr, ram_wren=d_we, ram_data=d_wdata; f_gnt -> ram_addr=f_addr,
//     ram_wren=0; no grant -> ram_addr=f_addr, ram_wren=0. ram_data=d_wdata always (don't-care when wren=0).
//   - Latency: read granted in cycle N -> rvalid=1 and rdata=ram_q in cycle N+1. f_rvalid<=f_gnt;
//     d_rvalid<=d_gnt & ~d_we. Writes produce no rvalid; write commits at the grant edge.
//   - rdata outputs are 0 when the matching rvalid is 0 (no stale data leaks).
//   - Back-to-back grants allowed every cycle; alternating owners return data in grant order, one per cycle.
//   - Read-after-write same address on consecutive cycles returns the new value (RAM is write-then-read).
//   - Reset mid-operation: in-flight read discarded; rvalids 0 the cycle after rst deasserts unless a new grant.
//   - Address/data widths pass through unmodified; no address wrap logic here.
// STRUCTURE
//   - Shared defines include (mem_defs.vh): AW/DW defaults, STARVE_MAX default, WE_READ/WE_WRITE constants.
//   - One sub-module: imem_starve_ctr (saturating counter, inc/clr/sat outputs, width $clog2(STARVE_MAX+1)).
//   - Top: comb. grant mux, RAM drive mux, two rvalid flops, rdata gating. Flops use the team dff cell style.
// TESTING
//   1 Reset: rst=1 with f_req=d_req=1 -> f_gnt=d_gnt=ram_wren=0; after release, f_rvalid=d_rvalid=0.
//   2 Fetch only: f_req=1, f_addr=0..3 over 4 cycles -> f_gnt=1 each cycle; f_rvalid=1 cycles 1..4,
//     f_rdata=mem[0..3] in order.
//   3 Write then read: d_we=1,d_addr=16'h0010,d_wdata=16'hBEEF; next cycle d_we=0 same addr
//     -> ram_wren=1 then 0; d_rvalid=1 with d_rdata=16'hBEEF the cycle after the read; no rvalid for the write.
//   4 Starvation (STARVE_MAX=4): f_req and d_req held 1 continuously -> d_gnt 4 cycles, f_gnt 5th,
//     then pattern repeats (starve_cnt back to 0 after f_gnt).
//   5 Interleave: f_gnt cycle N, d_gnt (read) cycle N+1 -> f_rvalid only at N+1, d_rvalid only at N+2,
//     each rdata matches its own address; non-valid rdata reads 0.
//   6 Reset mid-read: grant read at N, rst=1 at N+1 -> f_rvalid/d_rvalid=0 at N+1 and N+2.

Source files
------------

// File: rtl/imem_port_arbiter_pkg.sv
// Shared constants and types for the instruction/data RAM port arbiter.
// Provides width defaults, the starvation limit and the write-enable encoding.
package imem_port_arbiter_pkg;

  localparam int DEF_AW         = 16;
  localparam int DEF_DW         = 16;
  localparam int DEF_STARVE_MAX = 4;

  localparam logic WE_READ  = 1'b0;
  localparam logic WE_WRITE = 1'b1;

  typedef struct packed {
    logic f;
    logic d;
  } rvalid_t;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port was denied.
// Ports: clk, rst (sync, high), inc_i, clr_i, sat_o (count == MAX).
module imem_starve_ctr
  import imem_port_arbiter_pkg::*;
#(
  parameter int MAX = DEF_STARVE_MAX,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign sat_o = (cnt_q == CW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !sat_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one synchronous single-port RAM between fetch (read) and data (r/w).
// Ports: f_* fetch side, d_* data side, ram_* to RAM; read data 1 cycle late.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q
);

  logic    starved;
  logic    f_win;
  logic    f_deny;
  rvalid_t rv_q;
  rvalid_t rv_d;

  imem_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (f_deny),
    .clr_i (!f_deny),
    .sat_o (starved)
  );

  // Data wins ties unless fetch has waited STARVE_MAX cycles.
  assign f_win  = f_req && (!d_req || starved);
  assign f_gnt  = !rst && f_win;
  assign d_gnt  = !rst && d_req && !f_win;
  assign f_deny = f_req && !f_gnt;

  assign ram_addr = d_gnt ? d_addr : f_addr;
  assign ram_wren = d_gnt && (d_we == WE_WRITE);
  assign ram_data = d_wdata;

  always_comb begin
    rv_d   = '0;
    rv_d.f = f_gnt;
    rv_d.d = d_gnt && (d_we == WE_READ);
  end

  always_ff @(posedge clk) begin
    if (rst) rv_q <= '0;
    else     rv_q <= rv_d;
  end

  // Masking with rst drops a read whose data would land during reset.
  assign f_rvalid = rv_q.f && !rst;
  assign d_rvalid = rv_q.d && !rst;
  assign f_rdata  = f_rvalid ? ram_q : '0;
  assign d_rdata  = d_rvalid ? ram_q : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: directed table plus randomized traffic.
// Includes a behavioural RAM and a reference model of the arbitration rules.
module tb_imem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  always #5 clk = ~clk;

  imem_port_arbiter #(
    .AW (AW), .DW (DW), .STARVE_MAX (SM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren),
    .ram_q    (ram_q)
  );

  // Behavioural write-then-read RAM (256 words, low address bits).
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_addr[7:0]] <= ram_data;
      ram_q <= ram_data;
    end else begin
      ram_q <= mem[ram_addr[7:0]];
    end
  end

  typedef struct {
    bit          rst;
    bit          fr;
    logic [15:0] fa;
    bit          dr;
    bit          dw;
    logic [15:0] da;
    logic [15:0] dd;
    bit          e_fg;
    bit          e_dg;
    bit          e_we;
    bit          e_fv;
    logic [15:0] e_fd;
    bit          e_dv;
    logic [15:0] e_dd;
  } vec_t;

  vec_t vecs[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [DW-1:0] smem [256];
  int            m_starve;
  bit            m_fv, m_dv;
  logic [DW-1:0] m_fd, m_dd;

  function automatic vec_t mk(
    bit r, bit fr, logic [15:0] fa, bit dr, bit dw,
    logic [15:0] da, logic [15:0] dd,
    bit fg, bit dg, bit we, bit fv, logic [15:0] fdat,
    bit dv, logic [15:0] ddat);
    vec_t v;
    v.rst = r;   v.fr = fr;   v.fa = fa;
    v.dr = dr;   v.dw = dw;   v.da = da;   v.dd = dd;
    v.e_fg = fg; v.e_dg = dg; v.e_we = we;
    v.e_fv = fv; v.e_fd = fdat;
    v.e_dv = dv; v.e_dd = ddat;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h",
                  nm, idx, act, exp);
  endtask

  // Apply one cycle; compare against table fields or against the model.
  task automatic step(input vec_t v, input bit use_tab, input int idx);
    bit            fg, dg;
    logic [AW-1:0] ea;
    @(negedge clk);
    rst = v.rst;     f_req = v.fr;  f_addr = v.fa;
    d_req = v.dr;    d_we = v.dw;   d_addr = v.da;
    d_wdata = v.dd;
    #1;
    fg = !v.rst && v.fr && (!v.dr || m_starve == SM);
    dg = !v.rst && v.dr && !fg;
    if (use_tab) begin
      chk("f_gnt", idx, f_gnt, v.e_fg);
      chk("d_gnt", idx, d_gnt, v.e_dg);
      chk("ram_wren", idx, ram_wren, v.e_we);
      chk("f_rvalid", idx, f_rvalid, v.e_fv);
      chk("f_rdata", idx, f_rdata, v.e_fd);
      chk("d_rvalid", idx, d_rvalid, v.e_dv);
      chk("d_rdata", idx, d_rdata, v.e_dd);
    end else begin
      chk("m_f_gnt", idx, f_gnt, fg);
      chk("m_d_gnt", idx, d_gnt, dg);
      chk("m_ram_wren", idx, ram_wren, dg && v.dw);
      chk("m_f_rvalid", idx, f_rvalid, m_fv && !v.rst);
      chk("m_f_rdata", idx, f_rdata,
          (m_fv && !v.rst) ? m_fd : 16'h0);
      chk("m_d_rvalid", idx, d_rvalid, m_dv && !v.rst);
      chk("m_d_rdata", idx, d_rdata,
          (m_dv && !v.rst) ? m_dd : 16'h0);
    end
    ea = dg ? v.da : v.fa;
    if (fg || dg) chk("ram_addr", idx, ram_addr, ea);
    chk("ram_data", idx, ram_data, v.dd);
    // Advance the model past the coming clock edge.
    m_fv = fg;
    m_fd = smem[v.fa[7:0]];
    m_dv = dg && !v.dw;
    m_dd = smem[v.da[7:0]];
    if (dg && v.dw) smem[v.da[7:0]] = v.dd;
    if (v.rst) m_starve = 0;
    else if (v.fr && !fg) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
    else m_starve = 0;
  endtask

  initial begin
    bit            fh, dh;
    vec_t          rv;
    rst = 1'b1; f_req = 0; f_addr = '0; d_req = 0;
    d_we = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 16'hA000 + 16'(i);
      smem[i] = 16'hA000 + 16'(i);
    end
    m_starve = 0; m_fv = 0; m_dv = 0; m_fd = '0; m_dd = '0;

    //          rst fr fa     dr dw da     dd       fg dg we fv fd       dv dd
    // reset with both requesting
    vecs.push_back(mk(1,1,16'h0,1,1,16'h7,16'h1234, 0,0,0,0,16'h0,0,16'h0));
    vecs.push_back(mk(1,1,16'h0,1,1,16'h7,16'h1234, 0,0,0,0,16'h0,0,16'h0));
    // fetch only 0..3
    vecs.push_back(mk(0,1,16'h0,0,0,16'h0,16'h0, 1,0,0,0,16'h0,0,16'h0));
    vecs.push_back(mk(0,1,16'h1,0,0,16'h0,16'h0, 1,0,0,1,16'hA000,0,16'h0));
    vecs.push_back(mk(0,1,16'h2,0,0,16'h0,16'h0, 1,0,0,1,16'hA001,0,16'h0));
    vecs.push_back(mk(0,1,16'h3,0,0,16'h0,16'h0, 1,0,0,1,16'hA002,0,16'h0));
    vecs.push_back(mk(0,0,16'h0,0,0,16'h0,16'h0, 0,0,0,1,16'hA003,0,16'h0));
    // write BEEF then read it back
    vecs.push_back(mk(0,0,16'h0,1,1,16'h10,16'hBEEF, 0,1,1,0,16'h0,0,16'h0));
    vecs.push_back(mk(0,0,16'h0,1,0,16'h10,16'hBEEF, 0,1,0,0,16'h0,0,16'h0));
    vecs.push_back(mk(0,0,16'h0,0,0,16'h0,16'h0, 0,0,0,0,16'h0,1,16'hBEEF));
    // starvation: 4 data grants then a forced fetch, twice
    vecs.push_back(mk(0,1,16'h20,1,0,16'h5,16'h0, 0,1,0,0,16'h0,0,16'h0));
    vecs.push_back(mk(0,1,16'h20,1,0,16'h5,16'h0, 0,1,0,0,16'h0,1,16'hA005));
    vecs.push_back(mk(0,1,16'h20,1,0,16'h5,16'h0, 0,1,0,0,16'h0,1,16'hA005));
    vecs.push_back(mk(0,1,16'h20,1,0,16'h5,16'h0, 0,1,0,0,16'h0,1,16'hA005));
    vecs.push_back(mk(0,1,16'h20,1,0,16'h5,16'h0, 1,0,0,0,16'h0,1,16'hA005));
    vecs.push_back(mk(0,1,16'h20,1,0,16'h5,16'h0, 0,1,0,1,16'hA020,0,16'h0));
    vecs.push_back(mk(0,1,16'h20,1,0,16'h5,16'h0, 0,1,0,0,16'h0,1,16'hA005));
    vecs.push_back(mk(0,1,16'h20,1,0,16'h5,16'h0, 0,1,0,0,16'h0,1,16'hA005));
    vecs.push_back(mk(0,1,16'h20,1,0,16'h5,16'h0, 0,1,0,0,16'h0,1,16'hA005));
    vecs.push_back(mk(0,1,16'h20,1,0,16'h5,16'h0, 1,0,0,0,16'h0,1,16'hA005));
    // interleave fetch then data read
    vecs.push_back(mk(0,1,16'h30,0,0,16'h0,16'h0, 1,0,0,1,16'hA020,0,16'h0));
    vecs.push_back(mk(0,0,16'h0,1,0,16'h31,16'h0, 0,1,0,1,16'hA030,0,16'h0));
    vecs.push_back(mk(0,0,16'h0,0,0,16'h0,16'h0, 0,0,0,0,16'h0,1,16'hA031));
    // reset mid-read
    vecs.push_back(mk(0,1,16'h40,0,0,16'h0,16'h0, 1,0,0,0,16'h0,0,16'h0));
    vecs.push_back(mk(1,1,16'h40,0,0,16'h0,16'h0, 0,0,0,0,16'h0,0,16'h0));
    vecs.push_back(mk(0,0,16'h0,0,0,16'h0,16'h0, 0,0,0,0,16'h0,0,16'h0));
    // memory survives reset
    vecs.push_back(mk(0,0,16'h0,1,0,16'h10,16'h0, 0,1,0,0,16'h0,0,16'h0));
    vecs.push_back(mk(0,0,16'h0,0,0,16'h0,16'h0, 0,0,0,0,16'h0,1,16'hBEEF));

    foreach (vecs[i]) step(vecs[i], 1'b1, i);

    // Randomized traffic; requesters hold until granted.
    fh = 0; dh = 0;
    rv = mk(0,0,16'h0,0,0,16'h0,16'h0, 0,0,0,0,16'h0,0,16'h0);
    for (int c = 0; c < 600; c++) begin
      bit fg, dg;
      rv.rst = ($urandom_range(0, 49) == 0);
      if (!fh) begin
        rv.fr = ($urandom_range(0, 3) != 0);
        rv.fa = 16'($urandom_range(0, 15));
      end
      if (!dh) begin
        rv.dr = ($urandom_range(0, 2) != 0);
        rv.dw = $urandom_range(0, 1) == 1;
        rv.da = 16'($urandom_range(0, 15));
        rv.dd = 16'($urandom);
      end
      fg = !rv.rst && rv.fr && (!rv.dr || m_starve == SM);
      dg = !rv.rst && rv.dr && !fg;
      step(rv, 1'b0, 1000 + c);
      fh = rv.fr && !fg;
      dh = rv.dr && !dg;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
